pent_fetch_unit: RTL and testbench

//  Instruction fetch front end feeding the IF/ID stage register; consumer of the pipeline controller's IF stall/flush.

---
 rtl/pent_pipe_pkg.sv | 21 ++
 rtl/pent_fetch_fifo.sv | 65 ++++++
 rtl/pent_fetch_unit.sv | 113 +++++++++++
 tb/tb_pent_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pent_pipe_pkg.sv
// rtl/pent_pipe_pkg.sv - shared pipeline widths, fetch entry type and PC helpers
package pent_pipe_pkg;

  localparam int PC_W        = 48;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(INSTR_BYTES);
  endfunction

  function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/pent_fetch_fifo.sv
// rtl/pent_fetch_fifo.sv - prefetch FIFO of {pc, instr} entries with push/pop/clear
module pent_fetch_fifo
  import pent_pipe_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_push,
  input  fetch_entry_t  i_push_data,
  input  logic          i_pop,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push && !i_clear;
  assign w_pop   = i_pop && !o_empty && !i_clear;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pent_fetch_unit.sv
// rtl/pent_fetch_unit.sv - in-order instruction fetch with credit-limited prefetch and redirect flush
module pent_fetch_unit
  import pent_pipe_pkg::*;
#(
  parameter int              FIFO_DEPTH = 4,
  parameter int              MAX_OUTST  = 2,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               stall,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               if_valid,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instruction
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = CW + 1;

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_resp_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_fifo_count;
  logic [CW-1:0]   w_live;
  logic [CW-1:0]   w_inflight_after;
  logic [CRW-1:0]  w_credit;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  // Buffered words plus live in-flight requests never exceed the FIFO, so a push always has room.
  assign w_live           = r_inflight - r_drop_cnt;
  assign w_credit         = {1'b0, w_fifo_count} + {1'b0, w_live};
  assign w_inflight_after = r_inflight - CW'(imem_resp_valid);

  assign imem_req_valid = !reset && !redirect_valid
                          && (r_inflight < CW'(MAX_OUTST))
                          && (w_credit < CRW'(FIFO_DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_push = imem_resp_valid && (r_drop_cnt == '0) && !redirect_valid;
  assign w_pop  = !w_fifo_empty && !stall && !redirect_valid;

  assign w_push_entry.pc    = r_resp_pc;
  assign w_push_entry.instr = imem_resp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_inflight <= w_inflight_after + CW'(w_req_fire);
      if (redirect_valid) begin
        r_fetch_pc <= pc_align(redirect_pc);
        r_resp_pc  <= pc_align(redirect_pc);
        r_drop_cnt <= w_inflight_after;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= pc_next(r_fetch_pc);
        end
        if (w_push) begin
          r_resp_pc <= pc_next(r_resp_pc);
        end
        if (imem_resp_valid && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
      end
    end
  end

  pent_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  assign if_valid       = !w_fifo_empty;
  assign if_pc          = w_head.pc;
  assign if_instruction = w_head.instr;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && w_fifo_full && !w_pop));

  a_req_hold: assert property (@(posedge clk) disable iff (reset)
    (imem_req_valid && !imem_req_ready && !redirect_valid)
      |=> ((imem_req_valid || redirect_valid) && $stable(imem_req_addr)));

endmodule

// File: tb/tb_pent_fetch_unit.sv
// tb/tb_pent_fetch_unit.sv - directed self-checking bench for pent_fetch_unit
module tb_pent_fetch_unit;
  import pent_pipe_pkg::*;

  logic               clk;
  logic               reset;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               stall;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_resp_valid = 1'b0;
  logic [INSTR_W-1:0] imem_resp_data  = '0;
  logic               if_valid;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instruction;

  typedef struct {
    logic [PC_W-1:0] addr;
    int              due;
  } mreq_t;

  mreq_t              mq[$];
  logic [PC_W-1:0]    reqs[$];
  logic [PC_W-1:0]    pops[$];
  logic [INSTR_W-1:0] pop_instr[$];
  int                 cyc     = 0;
  int                 mem_lat = 1;
  int                 n_req   = 0;
  logic               nxt_v   = 1'b0;
  logic [INSTR_W-1:0] nxt_d   = '0;

  int                 n_checks = 0;
  int                 n_errors = 0;
  logic               prev_wait;
  logic [PC_W-1:0]    prev_addr;
  int                 viol;
  int                 bad;

  pent_fetch_unit #(
    .FIFO_DEPTH (4),
    .MAX_OUTST  (2),
    .RESET_PC   (48'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instruction  (if_instruction)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory returns addr-as-data in order, mem_lat cycles after the accepting cycle
  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      reqs.delete();
      pops.delete();
      pop_instr.delete();
      n_req = 0;
      nxt_v = 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
        reqs.push_back(imem_req_addr);
        n_req++;
      end
      if (if_valid && !stall && !redirect_valid) begin
        pops.push_back(if_pc);
        pop_instr.push_back(if_instruction);
      end
      nxt_v = 1'b0;
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        nxt_v = 1'b1;
        nxt_d = mq[0].addr[INSTR_W-1:0];
        mq.delete(0);
      end
    end
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    imem_resp_valid = nxt_v;
    imem_resp_data  = nxt_d;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input int lat);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat        = lat;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat        = 1;
    step();
    step();
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(imem_req_addr), 64'd0);
    chk("rst_if_pc", 64'(if_pc), 64'd0);
    chk("rst_if_instr", 64'(if_instruction), 64'd0);

    // 1: L=1 streaming, one instruction per cycle
    reset = 1'b0;
    #1;
    chk("t1_req_valid_c0", 64'(imem_req_valid), 64'd1);
    chk("t1_req_addr_c0", 64'(imem_req_addr), 64'd0);
    step();
    chk("t1_req_addr_c1", 64'(imem_req_addr), 64'd4);
    chk("t1_if_valid_c1", 64'(if_valid), 64'd0);
    step();
    chk("t1_if_valid_c2", 64'(if_valid), 64'd1);
    chk("t1_if_pc_c2", 64'(if_pc), 64'd0);
    for (int k = 3; k <= 5; k++) begin
      step();
      chk("t1_if_pc", 64'(if_pc), 64'(4 * (k - 2)));
      chk("t1_if_instr", 64'(if_instruction), 64'(4 * (k - 2)));
    end

    // 2: stall from the start fills the FIFO, then drains without gaps
    start(1);
    stall = 1'b1;
    repeat (9) step();
    chk("t2_req_count", 64'(n_req), 64'd4);
    chk("t2_req_valid_full", 64'(imem_req_valid), 64'd0);
    chk("t2_if_valid", 64'(if_valid), 64'd1);
    chk("t2_if_pc_frozen", 64'(if_pc), 64'd0);
    step();
    stall = 1'b0;
    chk("t2_if_pc_release", 64'(if_pc), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t2_drain_pc", 64'(if_pc), 64'(4 * k));
      chk("t2_drain_valid", 64'(if_valid), 64'd1);
    end

    // 3: L=3, two stale requests in flight at the redirect
    start(3);
    step();
    step();
    chk("t3_req_valid_outst", 64'(imem_req_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 48'h100;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t3_addr_after_redir", 64'(imem_req_addr), 64'h100);
    chk("t3_req_valid_c3", 64'(imem_req_valid), 64'd0);
    chk("t3_if_valid_c3", 64'(if_valid), 64'd0);
    step();
    chk("t3_req_valid_c4", 64'(imem_req_valid), 64'd1);
    chk("t3_req_addr_c4", 64'(imem_req_addr), 64'h100);
    for (int k = 4; k <= 7; k++) begin
      chk("t3_no_stale", 64'(if_valid), 64'd0);
      if (k < 7) step();
    end
    step();
    chk("t3_first_valid", 64'(if_valid), 64'd1);
    chk("t3_first_pc", 64'(if_pc), 64'h100);
    chk("t3_first_instr", 64'(if_instruction), 64'h100);
    step();
    chk("t3_second_pc", 64'(if_pc), 64'h104);

    // 4: redirect collides with a response and a pop
    start(1);
    step();
    step();
    step();
    chk("t4_if_pc_c3", 64'(if_pc), 64'd4);
    chk("t4_resp_c3", 64'(imem_resp_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 48'h200;
    #1;
    chk("t4_req_valid_redir", 64'(imem_req_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4_if_valid_c4", 64'(if_valid), 64'd0);
    chk("t4_req_valid_c4", 64'(imem_req_valid), 64'd1);
    chk("t4_req_addr_c4", 64'(imem_req_addr), 64'h200);
    step();
    chk("t4_if_valid_c5", 64'(if_valid), 64'd0);
    step();
    chk("t4_if_valid_c6", 64'(if_valid), 64'd1);
    chk("t4_if_pc_c6", 64'(if_pc), 64'h200);

    // 5: unaligned redirect near the top of the address space wraps
    start(1);
    redirect_valid = 1'b1;
    redirect_pc    = 48'hFFFF_FFFF_FFFE;
    #1;
    chk("t5_req_valid_redir", 64'(imem_req_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t5_addr0", 64'(imem_req_addr), 64'hFFFF_FFFF_FFFC);
    chk("t5_valid0", 64'(imem_req_valid), 64'd1);
    step();
    chk("t5_addr1", 64'(imem_req_addr), 64'd0);
    step();
    chk("t5_addr2", 64'(imem_req_addr), 64'd4);
    chk("t5_if_pc0", 64'(if_pc), 64'hFFFF_FFFF_FFFC);
    chk("t5_if_instr0", 64'(if_instruction), 64'hFFFF_FFFC);
    step();
    chk("t5_if_pc1", 64'(if_pc), 64'd0);
    step();
    chk("t5_if_pc2", 64'(if_pc), 64'd4);

    // 6: random ready backpressure, then reset mid-burst
    start(2);
    prev_wait = 1'b0;
    prev_addr = '0;
    viol      = 0;
    for (int i = 0; i < 30; i++) begin
      if (prev_wait && !(imem_req_valid && imem_req_addr == prev_addr)) viol++;
      imem_req_ready = 1'($urandom_range(0, 1));
      #1;
      prev_wait = imem_req_valid && !imem_req_ready;
      prev_addr = imem_req_addr;
      step();
    end
    chk("t6_addr_stable", 64'(viol), 64'd0);
    bad = 0;
    foreach (reqs[i]) if (reqs[i] != PC_W'(4 * i)) bad++;
    chk("t6_req_seq", 64'(bad), 64'd0);
    bad = 0;
    foreach (pops[i]) if (pops[i] != PC_W'(4 * i) || pop_instr[i] != INSTR_W'(4 * i)) bad++;
    chk("t6_pop_seq", 64'(bad), 64'd0);
    chk("t6_pops_seen", 64'(pops.size() > 2), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_if_valid", 64'(if_valid), 64'd0);
    chk("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t6_rst_req_addr", 64'(imem_req_addr), 64'd0);
    chk("t6_rst_if_pc", 64'(if_pc), 64'd0);
    chk("t6_rst_if_instr", 64'(if_instruction), 64'd0);
    step();
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("t6_restart_valid", 64'(imem_req_valid), 64'd1);
    chk("t6_restart_addr", 64'(imem_req_addr), 64'd0);
    step();
    chk("t6_restart_addr1", 64'(imem_req_addr), 64'd4);
    step();
    chk("t6_outst_limit", 64'(imem_req_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
